// File: rtl/seq_decoder_if.sv
// Control/status bundle for seq_decoder: the controller drives enable, mode, address,
// load and direction. The decoder returns the one-hot lines, the index and the wrap pulse.
interface seq_decoder_if #(
    parameter int N = 3
);
    logic              en;
    logic              mode;
    logic [N-1:0]      A;
    logic              load;
    logic              dir;
    logic [(1<<N)-1:0] D;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (output en, mode, A, load, dir, input D, idx, wrap);
    modport slave  (input en, mode, A, load, dir, output D, idx, wrap);
endinterface

// File: rtl/seq_decoder.sv
// N-to-2^N one-hot decoder. It either decodes A directly or auto-scans through all
// lines, dwelling DIV cycles on each line. D, idx and wrap are all registered.
module seq_decoder #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_decoder_if.slave bus
);
    localparam int W  = 1 << N;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t        state, state_next;
    logic [W-1:0]  d_q, d_next;
    logic [N-1:0]  idx_q, idx_next;
    logic [DW-1:0] dwell_q, dwell_next;
    logic          wrap_q, wrap_next;

    function automatic logic [W-1:0] one_hot(input logic [N-1:0] i);
        return W'(1) << i;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        dwell_next = '0;
        wrap_next  = 1'b0;
        if (!bus.en) begin
            state_next = IDLE;
        end else if (!bus.mode) begin
            state_next = DIRECT;
            idx_next   = bus.A;
        end else begin
            state_next = SCAN;
            // The entry edge from IDLE/DIRECT only restarts the dwell. Load and step act only once already scanning.
            if (state == SCAN) begin
                if (bus.load) begin
                    idx_next = bus.A;
                end else if (dwell_q == DWELL_LAST) begin
                    if (bus.dir) begin
                        idx_next  = idx_q - 1'b1;
                        wrap_next = (idx_q == '0);
                    end else begin
                        idx_next  = idx_q + 1'b1;
                        wrap_next = (idx_q == IDX_LAST);
                    end
                end else begin
                    dwell_next = dwell_q + 1'b1;
                end
            end
        end
        d_next = (state_next == IDLE) ? '0 : one_hot(idx_next);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            d_q     <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_next;
            d_q     <= d_next;
            idx_q   <= idx_next;
            dwell_q <= dwell_next;
            wrap_q  <= wrap_next;
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule
